// File: rtl/bram_pkg.sv
// Shared definitions for the pipelined simple-dual-port BRAM and its clear sequencer.
package bram_pkg;

    localparam int unsigned BRAM_READ_LATENCY_MIN = 1;
    localparam int unsigned BRAM_READ_LATENCY_MAX = 2;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } bram_state_t;

    // Number of byte-enable lanes in one word.
    function automatic int unsigned bram_lanes(input int unsigned data_width,
                                               input int unsigned byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/bram_clear_sequencer.sv
// Post-reset zeroing sweep for bram_dual_port_pipelined.
// Only compiled when BRAM_CLEAR_ON_RESET_EN is defined.
`ifdef BRAM_CLEAR_ON_RESET_EN
module bram_clear_sequencer
    import bram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ready,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  clr_en
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    bram_state_t           state;
    bram_state_t           state_next;
    logic [ADDR_WIDTH-1:0] cnt_next;
    logic                  ready_next;
    logic                  clr_en_next;

    // State, sweep address and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
            ready    <= 1'b0;
            clr_en   <= 1'b1;
        end else begin
            state    <= state_next;
            clr_addr <= cnt_next;
            ready    <= ready_next;
            clr_en   <= clr_en_next;
        end
    end

    // Sweep every address once, then hold RUN until the next reset.
    always_comb begin
        state_next  = state;
        cnt_next    = clr_addr;
        case (state)
            CLEAR: begin
                cnt_next = clr_addr + ADDR_WIDTH'(1);
                if (clr_addr == LAST_ADDR) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
            end
            RUN:     state_next = RUN;
            default: state_next = CLEAR;
        endcase
        ready_next  = (state_next == RUN);
        clr_en_next = (state_next == CLEAR);
    end

endmodule
`endif

// File: rtl/bram_dual_port_pipelined.sv
// Simple-dual-port block RAM with byte enables, 1/2-cycle registered read,
// selectable read-during-write forwarding and READY indication.
// Optional post-reset zeroing sweep: define BRAM_CLEAR_ON_RESET_EN.
module bram_dual_port_pipelined
    import bram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 9,
    parameter int unsigned BYTE_WIDTH   = 8,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned FORWARD      = 1
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic [DATA_WIDTH-1:0]            DI,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] BE,
    input  logic [ADDR_WIDTH-1:0]            WR_ADDR,
    input  logic                             WE,
    input  logic [ADDR_WIDTH-1:0]            RD_ADDR,
    input  logic                             RE,
    output logic [DATA_WIDTH-1:0]            DO,
    output logic                             DO_VALID,
    output logic                             READY
);

    localparam int unsigned LANES  = bram_lanes(DATA_WIDTH, BYTE_WIDTH);
    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned RD_LAT = (READ_LATENCY >= BRAM_READ_LATENCY_MAX) ?
                                     BRAM_READ_LATENCY_MAX : BRAM_READ_LATENCY_MIN;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [LANES-1:0]      wr_be;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;

`ifdef BRAM_CLEAR_ON_RESET_EN
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  clr_en;

    bram_clear_sequencer #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear (
        .clk      (CLK),
        .rst      (RST),
        .ready    (ready),
        .clr_addr (clr_addr),
        .clr_en   (clr_en)
    );

    // Clear sweep owns the write port until READY rises.
    always_comb begin
        wr_en   = WE & ready;
        wr_addr = WR_ADDR;
        wr_data = DI;
        wr_be   = BE;
        if (!ready) begin
            wr_en   = clr_en;
            wr_addr = clr_addr;
            wr_data = '0;
            wr_be   = '1;
        end
    end
`else
    assign ready = 1'b1;

    // User port drives the memory write directly.
    always_comb begin
        wr_en   = WE & ready;
        wr_addr = WR_ADDR;
        wr_data = DI;
        wr_be   = BE;
    end
`endif

    assign READY = ready;
    assign rd_en = RE & ready;

    // Byte-lane write; a write coinciding with reset is dropped.
    always_ff @(posedge CLK) begin
        if (!RST && wr_en) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Read word with optional same-address forwarding of the enabled write lanes.
    always_comb begin
        rd_word = mem[RD_ADDR];
        if (FORWARD != 0 && wr_en && (wr_addr == RD_ADDR)) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (wr_be[i]) begin
                    rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // First read stage; data forced to zero when no read was accepted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_en;
            s1_data  <= rd_en ? rd_word : '0;
        end
    end

    generate
        if (RD_LAT == BRAM_READ_LATENCY_MAX) begin : g_lat2
            logic                  s2_valid;
            logic [DATA_WIDTH-1:0] s2_data;

            // Extra output register stage.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    s2_data  <= s1_data;
                end
            end

            assign DO       = s2_data;
            assign DO_VALID = s2_valid;
        end else begin : g_lat1
            assign DO       = s1_data;
            assign DO_VALID = s1_valid;
        end
    endgenerate

endmodule

// File: tb/tb_bram_dual_port_pipelined.sv
// Scoreboard bench for bram_dual_port_pipelined: three instances share stimulus
// (latency1/forward, latency1/no-forward, latency2/forward) against one memory model.
// Define BRAM_CLEAR_ON_RESET_EN to exercise the clear sweep.
module tb_bram_dual_port_pipelined;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 4;
    localparam int unsigned BW = 8;
    localparam int unsigned NL = DW / BW;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] di;
    logic [NL-1:0] be;
    logic [AW-1:0] wa;
    logic          we;
    logic [AW-1:0] ra;
    logic          re;

    logic [DW-1:0] do_a, do_b, do_c;
    logic          vld_a, vld_b, vld_c;
    logic          rdy_a, rdy_b, rdy_c;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    exp_t        qa[$];
    exp_t        qb[$];
    exp_t        qc[$];
    logic [31:0] mem_m [16];
    logic        ready_m;
    int          clr_m;

    always #5 clk = ~clk;

    bram_dual_port_pipelined #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW), .READ_LATENCY(1), .FORWARD(1)
    ) dut_a (
        .CLK(clk), .RST(rst), .DI(di), .BE(be), .WR_ADDR(wa), .WE(we),
        .RD_ADDR(ra), .RE(re), .DO(do_a), .DO_VALID(vld_a), .READY(rdy_a)
    );

    bram_dual_port_pipelined #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW), .READ_LATENCY(1), .FORWARD(0)
    ) dut_b (
        .CLK(clk), .RST(rst), .DI(di), .BE(be), .WR_ADDR(wa), .WE(we),
        .RD_ADDR(ra), .RE(re), .DO(do_b), .DO_VALID(vld_b), .READY(rdy_b)
    );

    bram_dual_port_pipelined #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW), .READ_LATENCY(2), .FORWARD(1)
    ) dut_c (
        .CLK(clk), .RST(rst), .DI(di), .BE(be), .WR_ADDR(wa), .WE(we),
        .RD_ADDR(ra), .RE(re), .DO(do_c), .DO_VALID(vld_c), .READY(rdy_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: accepts, byte merge, forwarding and clear sweep.
    always @(posedge clk) begin
        logic [31:0] old_w;
        logic [31:0] fwd_w;
        cyc++;
        if (rst) begin
            qa.delete();
            qb.delete();
            qc.delete();
`ifdef BRAM_CLEAR_ON_RESET_EN
            ready_m = 1'b0;
`else
            ready_m = 1'b1;
`endif
            clr_m = 0;
        end else if (ready_m) begin
            if (re) begin
                old_w = mem_m[ra];
                fwd_w = old_w;
                if (we && wa == ra) begin
                    for (int l = 0; l < int'(NL); l++)
                        if (be[l]) fwd_w[l*8 +: 8] = di[l*8 +: 8];
                end
                qa.push_back('{due: cyc,     data: fwd_w});
                qb.push_back('{due: cyc,     data: old_w});
                qc.push_back('{due: cyc + 1, data: fwd_w});
            end
            if (we) begin
                for (int l = 0; l < int'(NL); l++)
                    if (be[l]) mem_m[wa][l*8 +: 8] = di[l*8 +: 8];
            end
        end else begin
            mem_m[clr_m] = 32'h0;
            if (clr_m == 15) ready_m = 1'b1;
            clr_m++;
        end
    end

    // Output monitor on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (cyc >= 1) begin
            check("ready_a", 32'(rdy_a), 32'(ready_m));
            check("ready_b", 32'(rdy_b), 32'(ready_m));
            check("ready_c", 32'(rdy_c), 32'(ready_m));
            if (qa.size() != 0 && qa[0].due == cyc) begin
                e = qa.pop_front();
                check("valid_a", 32'(vld_a), 32'd1);
                check("do_a", do_a, e.data);
            end else begin
                check("valid_a", 32'(vld_a), 32'd0);
                check("do_a_idle", do_a, 32'h0);
            end
            if (qb.size() != 0 && qb[0].due == cyc) begin
                e = qb.pop_front();
                check("valid_b", 32'(vld_b), 32'd1);
                check("do_b", do_b, e.data);
            end else begin
                check("valid_b", 32'(vld_b), 32'd0);
                check("do_b_idle", do_b, 32'h0);
            end
            if (qc.size() != 0 && qc[0].due == cyc) begin
                e = qc.pop_front();
                check("valid_c", 32'(vld_c), 32'd1);
                check("do_c", do_c, e.data);
            end else begin
                check("valid_c", 32'(vld_c), 32'd0);
                check("do_c_idle", do_c, 32'h0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        wa = a; di = d; be = b; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        ra = a; re = 1'b1;
        tick();
        re = 1'b0;
    endtask

    // Wait for READY with random traffic (must be ignored); report cycles waited.
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!rdy_a && n < 64) begin
            we = 1'($urandom); re = 1'($urandom);
            wa = 4'($urandom); ra = 4'($urandom);
            di = $urandom;     be = 4'($urandom);
            tick();
            n++;
        end
        we = 1'b0; re = 1'b0;
`ifdef BRAM_CLEAR_ON_RESET_EN
        check(tag, 32'(n), 32'd16);
`else
        check(tag, 32'(n), 32'd0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0;
        wa = '0; ra = '0; di = '0; be = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        wait_ready("sweep_len_init");

        // Fill every address so all later reads are defined.
        for (int i = 0; i < 16; i++) wr(4'(i), 32'hA500_0000 | (32'(i) * 32'h0001_0101), 4'hF);
        wr(4'd5, 32'h1122_3344, 4'hF);
        wr(4'd7, 32'h0000_0000, 4'hF);
        wr(4'd9, 32'h0000_0055, 4'hF);
        tick();

        // Write then read next cycle.
        wr(4'd3, 32'hDEAD_BEEF, 4'hF);
        rd(4'd3);
        tick(); tick();

        // Byte-enable merge.
        wr(4'd5, 32'hAABB_CCDD, 4'b0101);
        rd(4'd5);
        tick(); tick();

        // Same-cycle collision, then re-read.
        wa = 4'd7; di = 32'hCAFE_F00D; be = 4'b0011; we = 1'b1;
        ra = 4'd7; re = 1'b1;
        tick();
        we = 1'b0; re = 1'b0;
        rd(4'd7);
        tick(); tick();

        // Back-to-back streaming over all addresses.
        for (int i = 0; i < 16; i++) begin
            ra = 4'(i); re = 1'b1;
            tick();
        end
        re = 1'b0;
        tick(); tick(); tick();

        // Random mixed traffic.
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom); re = 1'($urandom);
            wa = 4'($urandom); ra = 4'($urandom);
            di = $urandom;     be = 4'($urandom);
            tick();
        end
        we = 1'b0; re = 1'b0;
        tick(); tick(); tick();

        // Reset one cycle after a read; concurrent write must be discarded.
        rd(4'd3);
        rst = 1'b1;
        wa = 4'd3; di = 32'h1234_5678; be = 4'hF; we = 1'b1;
        tick();
        we = 1'b0; rst = 1'b0;
        wait_ready("sweep_len_after_rd");
        rd(4'd3);
        tick(); tick();

`ifdef BRAM_CLEAR_ON_RESET_EN
        // Reset in the middle of the sweep restarts it.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            we = 1'($urandom); re = 1'($urandom);
            wa = 4'($urandom); ra = 4'($urandom);
            di = $urandom;     be = 4'($urandom);
            tick();
        end
        we = 1'b0; re = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_ready("sweep_len_restart");
`endif

        // Address 9 after the resets.
        rd(4'd9);
        rd(4'd5);
        tick(); tick(); tick();

        check("queues_drained", 32'(qa.size() + qb.size() + qc.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
